// File: rtl/vc_pop_scheduler.sv
// Round-robin pop scheduler merging four VC FIFOs onto one stream, with a
// hysteresis pause on downstream occupancy and the FIFO threshold registers.
module vc_pop_scheduler #(
  parameter int unsigned TAMANO_DATOS = 12,
  parameter int unsigned UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRALES_L_H-1:0] umbral_L_in,
  input  logic [UMBRALES_L_H-1:0] umbral_H_in,
  input  logic [3:0]              fifo_empty,
  input  logic [TAMANO_DATOS-1:0] fifo_data0,
  input  logic [TAMANO_DATOS-1:0] fifo_data1,
  input  logic [TAMANO_DATOS-1:0] fifo_data2,
  input  logic [TAMANO_DATOS-1:0] fifo_data3,
  input  logic [UMBRALES_L_H-1:0] dest_count,
  output logic [3:0]              pop,
  output logic [UMBRALES_L_H-1:0] umbral_L,
  output logic [UMBRALES_L_H-1:0] umbral_H,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic [1:0]              vc_out,
  output logic                    paused,
  output logic                    idle,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StInit   = 2'd1,
    StIdle   = 2'd2,
    StActive = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0]              sel_q;
  logic                    valid_q;
  logic                    paused_q, paused_d;
  logic [UMBRALES_L_H-1:0] umbral_l_q, umbral_l_d;
  logic [UMBRALES_L_H-1:0] umbral_h_q, umbral_h_d;

  logic [1:0] grant;
  logic [1:0] idx;
  logic       any_req;
  logic       found;
  logic       pop_en;

  assign any_req = ~&fifo_empty;

  // First non-empty VC starting at the round-robin pointer.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && !fifo_empty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign pop_en = (state_q == StActive) && !init && !paused_q && any_req;

  always_comb begin
    pop = 4'b0000;
    if (pop_en) pop[grant] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    umbral_l_d = umbral_l_q;
    umbral_h_d = umbral_h_q;
    paused_d   = paused_q;

    if (pop_en) rr_ptr_d = grant + 2'd1;

    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (!init) state_d = StIdle;
      StIdle: begin
        if (init)         state_d = StInit;
        else if (any_req) state_d = StActive;
      end
      StActive: begin
        if (init)          state_d = StInit;
        else if (!any_req) state_d = StIdle;
      end
      default:  state_d = StReset;
    endcase

    // Pause is held clear while thresholds are unsettled; set wins on overlap.
    if (state_q == StInit || state_q == StReset) begin
      paused_d = 1'b0;
    end else if (dest_count >= umbral_h_q) begin
      paused_d = 1'b1;
    end else if (dest_count <= umbral_l_q) begin
      paused_d = 1'b0;
    end

    if (state_q == StInit) begin
      umbral_l_d = umbral_L_in;
      umbral_h_d = umbral_H_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StReset;
      rr_ptr_q   <= 2'd0;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
      paused_q   <= 1'b0;
      umbral_l_q <= '0;
      umbral_h_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= grant;
      valid_q    <= |pop;
      paused_q   <= paused_d;
      umbral_l_q <= umbral_l_d;
      umbral_h_q <= umbral_h_d;
    end
  end

  // FIFO read data arrives the cycle after its pop, so mux on the registered select.
  always_comb begin
    data_out = '0;
    if (valid_q) begin
      unique case (sel_q)
        2'd0:    data_out = fifo_data0;
        2'd1:    data_out = fifo_data1;
        2'd2:    data_out = fifo_data2;
        default: data_out = fifo_data3;
      endcase
    end
  end

  assign valid_out = valid_q;
  assign vc_out    = sel_q;
  assign paused    = paused_q;
  assign idle      = (state_q == StIdle);
  assign state     = state_q;
  assign umbral_L  = umbral_l_q;
  assign umbral_H  = umbral_h_q;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Directed bench for vc_pop_scheduler: reset/init, round-robin, skip-empty,
// hysteresis pause, init mid-stream and asynchronous reset mid-stream.
module tb_vc_pop_scheduler;

  logic        clk;
  logic        reset;
  logic        init;
  logic [7:0]  umbral_L_in;
  logic [7:0]  umbral_H_in;
  logic [3:0]  fifo_empty;
  logic [11:0] fifo_data0;
  logic [11:0] fifo_data1;
  logic [11:0] fifo_data2;
  logic [11:0] fifo_data3;
  logic [7:0]  dest_count;
  logic [3:0]  pop;
  logic [7:0]  umbral_L;
  logic [7:0]  umbral_H;
  logic [11:0] data_out;
  logic        valid_out;
  logic [1:0]  vc_out;
  logic        paused;
  logic        idle;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  vc_pop_scheduler #(
    .TAMANO_DATOS(12),
    .UMBRALES_L_H(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .umbral_L_in(umbral_L_in),
    .umbral_H_in(umbral_H_in),
    .fifo_empty (fifo_empty),
    .fifo_data0 (fifo_data0),
    .fifo_data1 (fifo_data1),
    .fifo_data2 (fifo_data2),
    .fifo_data3 (fifo_data3),
    .dest_count (dest_count),
    .pop        (pop),
    .umbral_L   (umbral_L),
    .umbral_H   (umbral_H),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .vc_out     (vc_out),
    .paused     (paused),
    .idle       (idle),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] vc,
                          input logic [11:0] d);
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    chk({tag, ".vc"},    32'(vc_out),    32'(vc));
    chk({tag, ".data"},  32'(data_out),  32'(d));
  endtask

  initial begin
    reset       = 1'b0;
    init        = 1'b0;
    umbral_L_in = 8'd0;
    umbral_H_in = 8'd0;
    fifo_empty  = 4'hF;
    fifo_data0  = 12'hA00;
    fifo_data1  = 12'hA01;
    fifo_data2  = 12'hA02;
    fifo_data3  = 12'hA03;
    dest_count  = 8'd0;

    #3;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.pop", 32'(pop), 32'd0);
    chk("rst.uL", 32'(umbral_L), 32'd0);
    chk("rst.uH", 32'(umbral_H), 32'd0);
    chk_beat("rst", 1'b0, 2'd0, 12'h000);
    chk("rst.paused", 32'(paused), 32'd0);
    chk("rst.idle", 32'(idle), 32'd0);

    cyc();
    reset       = 1'b1;
    init        = 1'b1;
    umbral_L_in = 8'd2;
    umbral_H_in = 8'd6;
    cyc();
    chk("init.state", 32'(state), 32'd1);
    chk("init.uL_early", 32'(umbral_L), 32'd0);
    cyc();
    chk("init.uL", 32'(umbral_L), 32'd2);
    chk("init.uH", 32'(umbral_H), 32'd6);
    init = 1'b0;
    cyc();
    chk("idle.state", 32'(state), 32'd2);
    chk("idle.idle", 32'(idle), 32'd1);
    fifo_empty = 4'b0000;
    #1;
    chk("idle.pop", 32'(pop), 32'd0);

    // Round-robin across four busy VCs.
    cyc();
    chk("rr0.state", 32'(state), 32'd3);
    chk("rr0.pop", 32'(pop), 32'b0001);
    chk("rr0.valid", 32'(valid_out), 32'd0);
    cyc();
    chk("rr1.pop", 32'(pop), 32'b0010);
    chk_beat("rr1", 1'b1, 2'd0, 12'hA00);
    cyc();
    chk("rr2.pop", 32'(pop), 32'b0100);
    chk_beat("rr2", 1'b1, 2'd1, 12'hA01);
    cyc();
    chk("rr3.pop", 32'(pop), 32'b1000);
    chk_beat("rr3", 1'b1, 2'd2, 12'hA02);
    cyc();
    chk("rr4.pop", 32'(pop), 32'b0001);
    chk_beat("rr4", 1'b1, 2'd3, 12'hA03);

    // Skip empty VCs; pointer is now 1.
    cyc();
    fifo_empty = 4'b1010;
    #1;
    chk("skip0.pop", 32'(pop), 32'b0100);
    chk_beat("skip0", 1'b1, 2'd0, 12'hA00);
    cyc();
    chk("skip1.pop", 32'(pop), 32'b0001);
    chk_beat("skip1", 1'b1, 2'd2, 12'hA02);
    cyc();
    chk("skip2.pop", 32'(pop), 32'b0100);
    chk_beat("skip2", 1'b1, 2'd0, 12'hA00);
    cyc();
    fifo_empty = 4'b1111;
    #1;
    chk("drain.pop", 32'(pop), 32'd0);
    chk_beat("drain", 1'b1, 2'd2, 12'hA02);
    cyc();
    chk("drain.state", 32'(state), 32'd2);
    chk_beat("drain_end", 1'b0, 2'd0, 12'h000);

    // Hysteresis with L=2, H=6; only VC0 has data, pointer is 3.
    fifo_empty = 4'b1110;
    dest_count = 8'd5;
    cyc();
    chk("hy5.paused", 32'(paused), 32'd0);
    chk("hy5.pop", 32'(pop), 32'b0001);
    dest_count = 8'd6;
    cyc();
    chk("hy6.paused", 32'(paused), 32'd1);
    chk("hy6.pop", 32'(pop), 32'd0);
    chk_beat("hy6", 1'b1, 2'd0, 12'hA00);
    dest_count = 8'd4;
    cyc();
    chk("hy4.paused", 32'(paused), 32'd1);
    chk("hy4.pop", 32'(pop), 32'd0);
    chk("hy4.valid", 32'(valid_out), 32'd0);
    dest_count = 8'd3;
    cyc();
    chk("hy3.paused", 32'(paused), 32'd1);
    chk("hy3.pop", 32'(pop), 32'd0);
    dest_count = 8'd2;
    cyc();
    chk("hy2.paused", 32'(paused), 32'd0);
    chk("hy2.pop", 32'(pop), 32'b0001);

    // Init mid-stream while popping VC2; pointer is 1.
    fifo_empty = 4'b1011;
    dest_count = 8'd0;
    #1;
    chk("mi0.pop", 32'(pop), 32'b0100);
    cyc();
    chk("mi1.pop", 32'(pop), 32'b0100);
    #1;
    init        = 1'b1;
    umbral_H_in = 8'd9;
    #1;
    chk("mi.pop_drop", 32'(pop), 32'd0);
    chk_beat("mi", 1'b1, 2'd2, 12'hA02);
    cyc();
    chk("mi.state", 32'(state), 32'd1);
    chk("mi.valid", 32'(valid_out), 32'd0);
    cyc();
    chk("mi.uH", 32'(umbral_H), 32'd9);
    chk("mi.uL", 32'(umbral_L), 32'd2);
    init       = 1'b0;
    fifo_empty = 4'b0000;
    cyc();
    chk("mi.idle", 32'(state), 32'd2);
    chk("mi.idle_pop", 32'(pop), 32'd0);
    cyc();
    chk("mi.resume", 32'(pop), 32'b1000);

    // Advance to a VC2 pop, then assert reset between edges.
    cyc();
    chk("ar0.pop", 32'(pop), 32'b0001);
    cyc();
    chk("ar1.pop", 32'(pop), 32'b0010);
    cyc();
    chk("ar2.pop", 32'(pop), 32'b0100);
    chk_beat("ar2", 1'b1, 2'd1, 12'hA01);
    #3;
    reset = 1'b0;
    #1;
    chk("ar.pop", 32'(pop), 32'd0);
    chk("ar.valid", 32'(valid_out), 32'd0);
    chk("ar.state", 32'(state), 32'd0);
    chk("ar.data", 32'(data_out), 32'd0);
    chk("ar.uH", 32'(umbral_H), 32'd0);
    #1;
    reset = 1'b1;
    cyc();
    chk("ar.post_state", 32'(state), 32'd1);
    chk("ar.post_valid", 32'(valid_out), 32'd0);
    cyc();
    chk("ar.post_idle", 32'(state), 32'd2);
    chk("ar.post_valid2", 32'(valid_out), 32'd0);
    cyc();
    chk("ar.restart_pop", 32'(pop), 32'b0001);
    chk("ar.restart_valid", 32'(valid_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
